// File: rtl/imm_gen_pipe_if.sv
// Decode-side valid/ready bus of the pipelined immediate generator.
// master drives instruction beats and consumes immediates; slave is the generator.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_ext_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, in_ext_op, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_ext_op, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: format decode into a 2-entry skid buffer (main + skid).
// Define IMM_GEN_RVC_EN to decode ext_op 3'b110 as the compressed CI format.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  imm_gen_pipe_if.slave bus
);
  localparam logic [2:0] OP_I = 3'b000;
  localparam logic [2:0] OP_U = 3'b001;
  localparam logic [2:0] OP_S = 3'b010;
  localparam logic [2:0] OP_B = 3'b011;
  localparam logic [2:0] OP_J = 3'b100;
  localparam logic [2:0] OP_Z = 3'b101;
`ifdef IMM_GEN_RVC_EN
  localparam logic [2:0] OP_CI = 3'b110;
`endif

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic             valid;
  } entry_t;

  entry_t      m_q, s_q, m_n, s_n, beat;
  logic        ready_q;
  logic [31:0] imm32;
  logic        illegal;
  logic        accept;
  logic        fire;

  logic [31:0] i;
  assign i = bus.in_instr;

`ifdef IMM_GEN_RVC_EN
  logic unused_instr;
  assign unused_instr = ^i[1:0];
`else
  logic unused_instr;
  assign unused_instr = ^i[6:0];
`endif

  // Every format is built as a 32-bit value whose bit 31 is the extension bit.
  always_comb begin
    imm32   = {{20{i[31]}}, i[31:20]};
    illegal = 1'b0;
    case (bus.in_ext_op)
      OP_I:    imm32 = {{20{i[31]}}, i[31:20]};
      OP_U:    imm32 = {i[31:12], 12'b0};
      OP_S:    imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_B:    imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OP_J:    imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      OP_Z:    imm32 = {27'b0, i[19:15]};
`ifdef IMM_GEN_RVC_EN
      OP_CI:   imm32 = {{26{i[12]}}, i[12], i[6:2]};
`endif
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    beat         = '0;
    beat.imm     = XLEN'($signed(imm32));
    beat.tag     = bus.in_tag;
    beat.illegal = illegal;
    beat.valid   = 1'b1;
  end

  assign accept = bus.in_valid & ready_q;
  assign fire   = m_q.valid & bus.out_ready;

  // Next-state of the two entries; flush wins over any same-cycle accept.
  always_comb begin
    m_n = m_q;
    s_n = s_q;
    if (flush) begin
      m_n.valid = 1'b0;
      s_n.valid = 1'b0;
    end else if (fire && s_q.valid) begin
      m_n = s_q;
      if (accept) s_n = beat;
      else        s_n.valid = 1'b0;
    end else if (fire) begin
      if (accept) m_n = beat;
      else        m_n.valid = 1'b0;
    end else if (m_q.valid) begin
      if (accept) s_n = beat;
    end else if (accept) begin
      m_n = beat;
    end
  end

  // ready is a pure state bit: low whenever the skid entry will be occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      s_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      m_q     <= m_n;
      s_q     <= s_n;
      ready_q <= ~s_n.valid;
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = m_q.valid;
  assign bus.out_imm     = m_q.imm;
  assign bus.out_tag     = m_q.tag;
  assign bus.out_illegal = m_q.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: RV32 and RV64 instances run the same beat stream.
module tb_imm_gen_pipe;
  typedef struct {
    logic [3:0]  tag;
    logic [63:0] imm;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic rand_rdy = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) b64 ();

  assign b64.in_valid  = b32.in_valid;
  assign b64.in_instr  = b32.in_instr;
  assign b64.in_ext_op = b32.in_ext_op;
  assign b64.in_tag    = b32.in_tag;
  assign b64.out_ready = b32.out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [2:0] op, input logic [3:0] tag);
    exp_t e;
    e.tag = tag;
    e.illegal = 1'b0;
    case (op)
      3'd0: e.imm = {{52{i[31]}}, i[31:20]};
      3'd1: e.imm = {{32{i[31]}}, i[31:12], 12'b0};
      3'd2: e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd3: e.imm = {{52{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      3'd4: e.imm = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      3'd5: e.imm = {59'b0, i[19:15]};
`ifdef IMM_GEN_RVC_EN
      3'd6: e.imm = {{58{i[12]}}, i[12], i[6:2]};
`endif
      default: begin
        e.imm = {{52{i[31]}}, i[31:20]};
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic send(input logic [31:0] instr, input logic [2:0] op, input logic [3:0] tag,
                      input logic [63:0] imm, input logic ill);
    exp_t e;
    int   n;
    e.tag = tag; e.imm = imm; e.illegal = ill;
    b32.in_valid = 1'b1; b32.in_instr = instr; b32.in_ext_op = op; b32.in_tag = tag;
    #1;
    n = 0;
    while (!b32.in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) check_eq("send_timeout", 64'(n), 64'd0);
    else q.push_back(e);
    @(negedge clk);
    b32.in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] instr, input logic [2:0] op, input logic [3:0] tag);
    exp_t e;
    e = model(instr, op, tag);
    send(instr, op, tag, e.imm, e.illegal);
  endtask

  // Output monitor, sampled mid-low-phase after the driver has settled.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      check_eq("valid_64_vs_32", 64'(b64.out_valid), 64'(b32.out_valid));
      if (b32.out_valid) begin
        check_eq("beat_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          check_eq("imm32", 64'(b32.out_imm), {32'b0, q[0].imm[31:0]});
          check_eq("imm64", b64.out_imm, q[0].imm);
          check_eq("tag", 64'(b32.out_tag), 64'(q[0].tag));
          check_eq("tag64", 64'(b64.out_tag), 64'(q[0].tag));
          check_eq("illegal", 64'(b32.out_illegal), 64'(q[0].illegal));
          if (b32.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) if (rand_rdy) b32.out_ready = 1'($urandom_range(0, 1));

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    check_eq("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_ext_op = '0; b32.in_tag = '0;
    b32.out_ready = 1'b1;
    #12;
    check_eq("rst_valid", 64'(b32.out_valid), 64'd0);
    check_eq("rst_imm", b64.out_imm, 64'd0);
    check_eq("rst_tag", 64'(b32.out_tag), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("ready_after_rst", 64'(b32.in_ready), 64'd1);
    @(negedge clk);

    // Directed formats with known results.
    send(32'hFFF00093, 3'b000, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    #1 check_eq("latency_valid", 64'(b32.out_valid), 64'd1);
    send(32'hFE000EE3, 3'b011, 4'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'h12345037, 3'b001, 4'd3, 64'h0000_0000_1234_5000, 1'b0);
    send(32'h80000037, 3'b001, 4'd4, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(32'hFFFF8073, 3'b101, 4'd5, 64'h0000_0000_0000_001F, 1'b0);
    send(32'hABC00013, 3'b111, 4'd6, 64'hFFFF_FFFF_FFFF_FABC, 1'b1);
`ifdef IMM_GEN_RVC_EN
    send(32'h0000107D, 3'b110, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
`else
    send(32'h0000107D, 3'b110, 4'd7, 64'h0, 1'b1);
`endif
    drain();

    // Backpressure: two beats fill the buffer, the third waits for out_ready.
    @(negedge clk);
    b32.out_ready = 1'b0;
    fork
      begin
        send(32'h00100093, 3'b000, 4'd1, 64'd1, 1'b0);
        send(32'h00200093, 3'b000, 4'd2, 64'd2, 1'b0);
        send(32'h00300093, 3'b000, 4'd3, 64'd3, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        #1 check_eq("bp_ready_low", 64'(b32.in_ready), 64'd0);
        repeat (2) @(negedge clk);
        b32.out_ready = 1'b1;
      end
    join
    drain();

    // Flush with both entries full and a beat waiting on the input.
    b32.out_ready = 1'b0;
    send(32'h00900093, 3'b000, 4'd9, 64'd9, 1'b0);
    send(32'h00A00093, 3'b000, 4'd10, 64'd10, 1'b0);
    b32.in_valid = 1'b1; b32.in_instr = 32'h00B00093; b32.in_ext_op = 3'b000; b32.in_tag = 4'd11;
    flush = 1'b1;
    @(posedge clk); #1 q.delete();
    @(negedge clk);
    flush = 1'b0; b32.in_valid = 1'b0;
    #1;
    check_eq("flush_full_valid", 64'(b32.out_valid), 64'd0);
    check_eq("flush_full_ready", 64'(b32.in_ready), 64'd1);

    // Flush beats a same-cycle accept while M is occupied.
    @(negedge clk);
    send(32'h00C00093, 3'b000, 4'd12, 64'd12, 1'b0);
    b32.in_valid = 1'b1; b32.in_instr = 32'h00D00093; b32.in_tag = 4'd13;
    flush = 1'b1;
    @(posedge clk); #1 q.delete();
    @(negedge clk);
    flush = 1'b0; b32.in_valid = 1'b0;
    #1 check_eq("flush_acc_valid", 64'(b32.out_valid), 64'd0);
    b32.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset between clock edges.
    b32.out_ready = 1'b0;
    send(32'hFFF00093, 3'b000, 4'd14, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    #3 rst = 1'b1;
    #1;
    check_eq("async_valid", 64'(b32.out_valid), 64'd0);
    check_eq("async_imm32", 64'(b32.out_imm), 64'd0);
    check_eq("async_imm64", b64.out_imm, 64'd0);
    check_eq("async_tag", 64'(b32.out_tag), 64'd0);
    q.delete();
    @(negedge clk); rst = 1'b0; b32.out_ready = 1'b1;
    @(posedge clk); #1 check_eq("ready_after_rst2", 64'(b32.in_ready), 64'd1);
    @(negedge clk);

    // Random formats with random consumer stalls.
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++)
      send_m($urandom, 3'($urandom_range(0, 7)), 4'(k));
    rand_rdy = 1'b0;
    @(negedge clk);
    b32.out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator. Sits between the decode and register-read stages.
- Accepts a full 32-bit instruction word plus extension opcode and a sideband tag over a valid/ready handshake.
- Produces a sign-extended immediate of XLEN bits, one cycle later, through a 2-entry skid buffer.
- Supports RV32/RV64 widths, a CSR zero-extended immediate, an illegal-op flag, and a pipeline flush.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 4, width of the opaque sideband tag carried with each immediate (e.g. ROB/PC index).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept an input beat
- in_instr  in  32  full instruction word
- in_ext_op  in  3  immediate format select
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts output beat
- out_imm  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag of the output beat
- out_illegal  out  1  ext_op was not a defined format

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - While rst is high: out_valid=0, out_imm=0, out_tag=0, out_illegal=0, both buffer entries invalid.
  - in_ready=1 from the first edge after rst deasserts.
- Format decode (combinational, on the input side). Let i = in_instr and sx() = sign-extend to XLEN from bit i[31].
  - 000 I: sx(i[31:20]).
  - 001 U: sx({i[31:12], 12'b0}). Bits above 31 are copies of i[31] when XLEN=64.
  - 010 S: sx({i[31:25], i[11:7]}).
  - 011 B: sx({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - 100 J: sx({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - 101 Z (CSR uimm): zero-extend i[19:15].
  - 110: reserved for the optional feature (see below); otherwise illegal.
  - 111: illegal.
  - Illegal formats: imm = I-format value, illegal flag = 1.
- Storage: main register M (drives the out_* ports) and skid register S. Each holds {imm, tag, illegal, valid}.
- Handshake:
  - accept = in_valid & in_ready. fire = out_valid & out_ready.
  - in_ready = ~S.valid. It is a registered state bit only, with no combinational path from out_ready.
  - out_valid = M.valid.
- Cycle-level updates, evaluated in this order:
  - fire & S.valid: M <= S. If accept, S <= new beat; otherwise S.valid <= 0.
  - fire & ~S.valid: M <= new beat if accept, else M.valid <= 0.
  - ~fire & M.valid & accept: S <= new beat. The block is then full and in_ready drops next cycle.
  - ~M.valid & accept: M <= new beat.
- Latency: an accepted beat appears on out_* on the next cycle when M is empty or firing.
- Throughput: 1 beat/cycle with out_ready held high.
- Ordering: strict FIFO; beats are never dropped or duplicated.
- Holding: out_imm, out_tag and out_illegal hold stable while out_valid=1 and out_ready=0.
- flush:
  - Clears M.valid and S.valid at the next edge.
  - Takes priority over a same-cycle accept, so the incoming beat is discarded.
  - A same-cycle fire completes normally from the consumer's view.
  - in_ready=1 the cycle after flush.
- Reset mid-operation: all contents are discarded immediately (asynchronous). No beat emerges after reset.

Optional Feature:
- Macro: IMM_GEN_RVC_EN.
- When defined: ext_op 110 = compressed CI format. Value is sx({i[12], i[6:2]}), with sign taken from i[12] and illegal=0.
- When undefined: ext_op 110 is illegal, producing the I-format value with out_illegal=1.
- Logic for the 110 decode must be absent from the netlist when the macro is undefined.

Test Plan:
- XLEN=32, in_instr=0xFFF00093, ext_op=000, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
- in_instr=0xFE000EE3, ext_op=011 -> out_imm=0xFFFFFFFC.
- in_instr=0x12345037, ext_op=001 -> out_imm=0x12345000.
  - Same beat with XLEN=64 -> 0x0000000012345000.
  - in_instr=0x80000037 with XLEN=64 -> 0xFFFFFFFF80000000.
- Backpressure: out_ready=0, three back-to-back beats with tags 1,2,3.
  - Tags 1 and 2 are accepted; in_ready=0 from cycle 2 and beat 3 is held.
  - out_ready=1 then yields tags 1,2,3 in order, one per cycle, with no loss.
- Flush with both entries full plus a same-cycle accept -> next cycle out_valid=0, in_ready=1, and the discarded beat never appears.
  - Assert rst asynchronously mid-stream -> outputs return to 0 without waiting for a clock edge.
- ext_op=111 -> out_illegal=1.
  - ext_op=110 with in_instr=0x0000107D: IMM_GEN_RVC_EN defined -> out_imm=0xFFFFFFFF, illegal=0.
  - Same beat with the macro undefined -> out_illegal=1.
